uart_tx_core: RTL
=================

UART_TX_CORE -- requirements
Module: uart_tx_core

Interface
REQ-001 SHALL have parameter P_SYSTEM_CLK, default 50_000_000: system clock frequency in Hz.
REQ-002 SHALL have parameter P_UART_BUADRATE, default 9600: line bit rate.
REQ-003 SHALL have parameter P_UART_DATA_WIDTH, default 8: data bits per frame, legal range 5..9.
REQ-004 SHALL have parameter P_UART_STOP_WIDTH, default 1: stop bits per frame, 1 or 2.
REQ-005 SHALL have parameter P_UART_CHECK, default 0: parity mode, 0 none, 1 odd, 2 even.
REQ-006 SHALL have port i_clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-007 SHALL have port i_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-008 SHALL have port i_user_tx_data, input, P_UART_DATA_WIDTH bits: byte to send.
REQ-009 SHALL have port i_user_tx_valid, input, 1 bit: i_user_tx_data is valid.
REQ-010 SHALL have port o_user_tx_ready, output, 1 bit: core can accept a byte.
REQ-011 SHALL have port o_uart_tx, output, 1 bit: serial line, idle high.
REQ-012 SHALL have port o_tx_busy, output, 1 bit: frame in progress.
REQ-013 SHALL have port o_tx_done, output, 1 bit: one-cycle pulse at frame end.

Function
REQ-014 SHALL derive bit period DIV = P_SYSTEM_CLK/P_UART_BUADRATE (integer division) from an internal baud counter; no divided clock SHALL be generated.
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-016 IDLE: o_user_tx_ready=1, o_uart_tx=1, o_tx_busy=0.
REQ-017 Handshake: a byte SHALL be accepted on the rising edge where i_user_tx_valid=1 and o_user_tx_ready=1; data SHALL be latched internally on that edge.
REQ-018 The cycle after acceptance SHALL enter START, with o_user_tx_ready=0, o_tx_busy=1, o_uart_tx=0.
REQ-019 Each bit SHALL be held on o_uart_tx for exactly DIV cycles; the baud counter SHALL reset to 0 at every bit boundary and at frame start.
REQ-020 DATA SHALL send P_UART_DATA_WIDTH bits, LSB first, tracked by a bit counter that wraps to 0 on leaving DATA.
REQ-021 When P_UART_CHECK=0, PARITY SHALL be skipped (DATA -> STOP).
REQ-022 When P_UART_CHECK=1, the parity bit SHALL equal ~^data; when P_UART_CHECK=2, it SHALL equal ^data. Parity SHALL be computed from the latched data.
REQ-023 STOP SHALL drive 1 for P_UART_STOP_WIDTH*DIV cycles.
REQ-024 o_tx_done SHALL be 1 only in the final cycle of the last stop bit; the next cycle SHALL be IDLE with o_user_tx_ready=1.
REQ-025 Frame length from the first START cycle to the end of the o_tx_done cycle SHALL be (1+P_UART_DATA_WIDTH+(P_UART_CHECK!=0)+P_UART_STOP_WIDTH)*DIV cycles.
REQ-026 Any change on i_user_tx_valid or i_user_tx_data while o_user_tx_ready=0 SHALL be ignored and SHALL NOT corrupt the frame in progress.
REQ-027 Back-to-back: if valid is held high, the next acceptance SHALL occur in the first IDLE cycle, giving exactly one idle-high cycle between frames.
REQ-028 o_uart_tx SHALL be driven from a register (glitch-free).

Reset
REQ-029 While i_rst_n=0: state=IDLE, counters=0, o_uart_tx=1, o_user_tx_ready=0, o_tx_busy=0, o_tx_done=0.
REQ-030 o_user_tx_ready SHALL rise on the first clock edge after i_rst_n deasserts.
REQ-031 Reset asserted mid-frame SHALL abort the frame immediately (line high), with no o_tx_done pulse; the aborted byte SHALL be discarded.

Verification (bench params P_SYSTEM_CLK=1_000_000, P_UART_BUADRATE=100_000, DIV=10)
REQ-032 8N1: send 0xA5 -> line 0 (10 cyc), bits 1,0,1,0,0,1,0,1, then 1 (10 cyc); done pulses at cycle 100; ready high at cycle 101.
REQ-033 8E1 and 8O1: send 0x07 -> even mode parity bit 1, odd mode parity bit 0; frame 110 cycles.
REQ-034 8N2: send 0xFF -> stop high 20 cycles; frame 110 cycles; single done pulse.
REQ-035 Valid held high with data 0x11 then 0x22 -> two frames separated by exactly 1 idle cycle; data changed mid-frame does not alter the first frame.
REQ-036 Assert i_rst_n=0 at cycle 45 of a frame -> o_uart_tx=1, busy=0, no done pulse; ready=1 one edge after release; the next send of 0x3C is transmitted correctly.

Source files
------------

// File: rtl/uart_tx_core.sv
// UART transmitter: start bit, 5..9 data bits LSB first, optional odd/even parity,
// 1 or 2 stop bits. All timing comes from an internal baud counter on i_clk.
module uart_tx_core #(
  parameter int P_SYSTEM_CLK      = 50_000_000,
  parameter int P_UART_BUADRATE   = 9600,
  parameter int P_UART_DATA_WIDTH = 8,
  parameter int P_UART_STOP_WIDTH = 1,
  parameter int P_UART_CHECK      = 0
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [P_UART_DATA_WIDTH-1:0] i_user_tx_data,
  input  logic                         i_user_tx_valid,
  output logic                         o_user_tx_ready,
  output logic                         o_uart_tx,
  output logic                         o_tx_busy,
  output logic                         o_tx_done
);

  localparam int DIV   = P_SYSTEM_CLK / P_UART_BUADRATE;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W = 4;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(P_UART_DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(P_UART_STOP_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e                       state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [BIT_W-1:0]             bit_cnt_q, bit_cnt_d;
  logic [P_UART_DATA_WIDTH-1:0] data_q, data_d;
  logic                         tx_q, tx_d;
  logic                         ready_q, ready_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;

  logic bit_end;
  logic bit_sel;
  logic parity_bit;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    bit_end   = (cnt_q == CNT_LAST);

    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        cnt_d     = '0;
        bit_cnt_d = '0;
        if (i_user_tx_valid && ready_q) begin
          state_d = S_START;
          data_d  = i_user_tx_data;
        end
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
            state_d   = (P_UART_CHECK != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        // bit_cnt doubles as the stop-bit counter for two-stop-bit frames.
        if (bit_end) begin
          if (bit_cnt_q == STOP_LAST) begin
            bit_cnt_d = '0;
            state_d   = S_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d   = S_IDLE;
        cnt_d     = '0;
        bit_cnt_d = '0;
      end
    endcase

    bit_sel = 1'b0;
    for (int i = 0; i < P_UART_DATA_WIDTH; i++) begin
      if (bit_cnt_d == BIT_W'(i)) bit_sel = data_d[i];
    end
    parity_bit = (P_UART_CHECK == 1) ? ~^data_d : ^data_d;

    // Outputs are decoded from the next state so the registered versions line
    // up exactly with the state they describe.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = bit_sel;
      S_PARITY: tx_d = parity_bit;
      default:  tx_d = 1'b1;
    endcase
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_STOP) && (bit_cnt_d == STOP_LAST) && (cnt_d == CNT_LAST);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      data_q    <= '0;
      tx_q      <= 1'b1;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      tx_q      <= tx_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign o_uart_tx       = tx_q;
  assign o_user_tx_ready = ready_q;
  assign o_tx_busy       = busy_q;
  assign o_tx_done       = done_q;

endmodule
